// File: rtl/teamd_serial_rx_controller.sv
// Receive sequencer for the TEAMD async serial line: start detect, 3-sample vote, shift strobes, stop check.
// Latency: 2-cycle input synchronizer; each result is registered one cycle after its third vote sample.
// Backpressure: none; the shift register must accept every ShiftEn strobe, and Enable low aborts at once.
module teamd_serial_rx_controller #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 7
) (
    input  logic CLK,
    input  logic RESET,
    input  logic Rx,
    input  logic Enable,
    output logic ShiftEn,
    output logic ShiftData,
    output logic iLoad,
    output logic FrameErr,
    output logic Busy
);

    localparam int MID = OVERSAMPLE / 2;
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] T_ONE   = TW'(1);
    localparam logic [TW-1:0] T_MIDM1 = TW'(MID - 1);
    localparam logic [TW-1:0] T_MID   = TW'(MID);
    localparam logic [TW-1:0] T_MIDP1 = TW'(MID + 1);
    localparam logic [TW-1:0] T_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state;
    logic [TW-1:0] tick;
    logic [BW-1:0] bit_cnt;
    logic          rx_m;
    logic          rx_s;
    logic          samp_a;
    logic          samp_b;
    logic          vote;

    // Two-flop synchronizer; resets to the idle (high) line level so reset never looks like a start bit
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= Rx;
            rx_s <= rx_m;
        end
    end

    // 2-of-3 vote across ticks MID-1, MID and the current MID+1 sample
    assign vote = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);

    // Frame sequencer with registered strobes; outputs default low so every pulse is one cycle wide
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= S_IDLE;
            tick      <= '0;
            bit_cnt   <= '0;
            samp_a    <= 1'b1;
            samp_b    <= 1'b1;
            ShiftEn   <= 1'b0;
            ShiftData <= 1'b0;
            iLoad     <= 1'b0;
            FrameErr  <= 1'b0;
            Busy      <= 1'b0;
        end else begin
            ShiftEn   <= 1'b0;
            ShiftData <= 1'b0;
            iLoad     <= 1'b0;
            FrameErr  <= 1'b0;
            if (!Enable) begin
                state   <= S_IDLE;
                tick    <= '0;
                bit_cnt <= '0;
                Busy    <= 1'b0;
            end else begin
                if (tick == T_MIDM1) samp_a <= rx_s;
                if (tick == T_MID)   samp_b <= rx_s;
                case (state)
                    S_IDLE: begin
                        // this cycle is tick 0 of the start bit
                        if (!rx_s) begin
                            state <= S_START;
                            tick  <= T_ONE;
                            Busy  <= 1'b1;
                        end
                    end
                    S_START: begin
                        if (tick == T_MIDP1 && vote) begin
                            state <= S_IDLE;
                            tick  <= '0;
                            Busy  <= 1'b0;
                        end else if (tick == T_LAST) begin
                            state   <= S_DATA;
                            tick    <= '0;
                            bit_cnt <= '0;
                        end else begin
                            tick <= tick + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (tick == T_MIDP1) begin
                            ShiftEn   <= 1'b1;
                            ShiftData <= vote;
                        end
                        if (tick == T_LAST) begin
                            tick <= '0;
                            if (bit_cnt == B_LAST) state <= S_STOP;
                            else                   bit_cnt <= bit_cnt + 1'b1;
                        end else begin
                            tick <= tick + 1'b1;
                        end
                    end
                    S_STOP: begin
                        // early return to idle lets a back-to-back start be caught without a gap
                        if (tick == T_MIDP1) begin
                            tick    <= '0;
                            bit_cnt <= '0;
                            if (vote) begin
                                iLoad <= 1'b1;
                                state <= S_IDLE;
                                Busy  <= 1'b0;
                            end else begin
                                FrameErr <= 1'b1;
                                state    <= S_BREAK;
                            end
                        end else begin
                            tick <= tick + 1'b1;
                        end
                    end
                    S_BREAK: begin
                        // a line held low must not re-trigger frames
                        if (rx_s) begin
                            state <= S_IDLE;
                            Busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        tick  <= '0;
                        Busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_teamd_serial_rx_controller.sv
// Bench for teamd_serial_rx_controller: directed frames from the test plan plus randomized line traffic.
// Expected outputs come from a frame-offset model driven by the recorded pin/enable/reset history.
module tb_teamd_serial_rx_controller;

    localparam int OS   = 16;
    localparam int DB   = 7;
    localparam int MID  = OS / 2;
    localparam int HMAX = 32000;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    logic Rx = 1'b1;
    logic Enable = 1'b1;
    logic ShiftEn, ShiftData, iLoad, FrameErr, Busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    teamd_serial_rx_controller #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
        .CLK(CLK), .RESET(RESET), .Rx(Rx), .Enable(Enable),
        .ShiftEn(ShiftEn), .ShiftData(ShiftData), .iLoad(iLoad),
        .FrameErr(FrameErr), .Busy(Busy)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- history, model and observation log ----------------
    bit pin_h [HMAX];
    bit en_h  [HMAX];
    bit rst_h [HMAX];
    bit rxs_h [HMAX];
    int last_rst = -1000;

    typedef enum {M_IDLE, M_FRAME, M_BRK} mmode_t;
    mmode_t mode = M_IDLE;
    int f = 0;

    int sh_cyc[$];
    bit sh_bit[$];
    int ld_cyc[$];
    int fe_cyc[$];
    int busy_cnt = 0;

    function automatic bit maj3(input bit a, input bit b, input bit c);
        return (int'(a) + int'(b) + int'(c)) >= 2;
    endfunction

    always @(negedge CLK) begin
        int c, p, o, n, t, base;
        bit v, e_se, e_sd, e_ld, e_fe, e_busy;
        c = cyc;
        if (c < HMAX) begin
            pin_h[c] = Rx;
            en_h[c]  = Enable;
            rst_h[c] = RESET;
            if (RESET) last_rst = c;
            rxs_h[c] = (RESET || (c - 2 <= last_rst)) ? 1'b1 : pin_h[c-2];
            e_se = 0; e_sd = 0; e_ld = 0; e_fe = 0;
            p = c - 1;
            if (RESET || p < 0 || rst_h[p]) begin
                mode = M_IDLE;
            end else if (!en_h[p]) begin
                mode = M_IDLE;
            end else begin
                case (mode)
                    M_IDLE: if (!rxs_h[p]) begin mode = M_FRAME; f = p; end
                    M_FRAME: begin
                        o = p - f; n = o / OS; t = o % OS;
                        if (t == MID + 1) begin
                            base = f + n * OS;
                            v = maj3(rxs_h[base + MID - 1], rxs_h[base + MID], rxs_h[p]);
                            if (n == 0) begin
                                if (v) mode = M_IDLE;
                            end else if (n <= DB) begin
                                e_se = 1; e_sd = v;
                            end else if (v) begin
                                e_ld = 1; mode = M_IDLE;
                            end else begin
                                e_fe = 1; mode = M_BRK;
                            end
                        end
                    end
                    default: if (rxs_h[p]) mode = M_IDLE;
                endcase
            end
            e_busy = (mode != M_IDLE);
            chk("shift_en", int'(ShiftEn), int'(e_se));
            if (e_se) chk("shift_data", int'(ShiftData), int'(e_sd));
            chk("iload", int'(iLoad), int'(e_ld));
            chk("frame_err", int'(FrameErr), int'(e_fe));
            chk("busy", int'(Busy), int'(e_busy));
            if (ShiftEn) begin sh_cyc.push_back(c); sh_bit.push_back(ShiftData); end
            if (iLoad) ld_cyc.push_back(c);
            if (FrameErr) fe_cyc.push_back(c);
            if (Busy) busy_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    bit pq[$];
    int drop_at = -1;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_log();
        sh_cyc.delete(); sh_bit.delete(); ld_cyc.delete(); fe_cyc.delete();
        busy_cnt = 0;
    endtask

    task automatic build(input logic [DB-1:0] data, input bit stop, input int gn, input int gt);
        bit b;
        pq.delete();
        for (int n = 0; n <= DB + 1; n++) begin
            b = (n == 0) ? 1'b0 : (n <= DB) ? data[n-1] : stop;
            for (int t = 0; t < OS; t++) pq.push_back((n == gn && t == gt) ? ~b : b);
        end
    endtask

    // Pin index i lands on rx_s at frame cycle i; Enable index i acts in frame cycle i-2
    task automatic play(input int limit, output int s);
        s = cyc;
        for (int i = 0; i < pq.size() && i < limit; i++) begin
            Rx = pq[i];
            if (drop_at >= 0 && i == drop_at) Enable = 1'b0;
            if (drop_at >= 0 && i == drop_at + 3) Enable = 1'b1;
            if (drop_at >= 0 && i == drop_at + 1) chk("abort_busy_low", int'(Busy), 0);
            step();
        end
        Enable = 1'b1;
        drop_at = -1;
    endtask

    task automatic idle(input int n);
        Rx = 1'b1;
        repeat (n) step();
    endtask

    function automatic int shifted_value(input int from);
        int val = 0;
        for (int k = 0; k < DB && from + k < sh_bit.size(); k++)
            val |= int'(sh_bit[from + k]) << k;
        return val;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int s, s2;
        bit [6:0] pat;
        pat = 7'h35;

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_shift_en", int'(ShiftEn), 0);
        chk("rst_shift_data", int'(ShiftData), 0);
        chk("rst_iload", int'(iLoad), 0);
        chk("rst_frame_err", int'(FrameErr), 0);
        chk("rst_busy", int'(Busy), 0);
        RESET = 1'b0;
        idle(10);

        // clean frame 7'h35
        clear_log();
        build(7'h35, 1'b1, -1, 0);
        play(1000, s);
        idle(20);
        chk("clean_strobes", sh_cyc.size(), 7);
        for (int k = 0; k < 7 && k < sh_cyc.size(); k++) begin
            chk("clean_strobe_cycle", sh_cyc[k] - (s + 2), 26 + 16 * k);
            chk("clean_bit", int'(sh_bit[k]), int'(pat[k]));
        end
        chk("clean_iload_count", ld_cyc.size(), 1);
        if (ld_cyc.size() > 0) chk("clean_iload_cycle", ld_cyc[0] - (s + 2), 138);
        chk("clean_frame_err_count", fe_cyc.size(), 0);

        // false start: 5 cycles low
        clear_log();
        Rx = 1'b0;
        repeat (5) step();
        idle(30);
        chk("false_start_shifts", sh_cyc.size(), 0);
        chk("false_start_busy_cycles", busy_cnt, 9);

        // framing error, held low, then a clean 7'h01
        clear_log();
        build(7'h7F, 1'b0, -1, 0);
        for (int i = 0; i < 40; i++) pq.push_back(1'b0);
        play(1000, s);
        chk("ferr_count", fe_cyc.size(), 1);
        if (fe_cyc.size() > 0) chk("ferr_cycle", fe_cyc[0] - (s + 2), 138);
        chk("ferr_no_iload", ld_cyc.size(), 0);
        chk("ferr_no_restart", sh_cyc.size(), 7);
        idle(5);
        clear_log();
        build(7'h01, 1'b1, -1, 0);
        play(1000, s2);
        idle(20);
        chk("after_ferr_iload", ld_cyc.size(), 1);
        chk("after_ferr_data", shifted_value(0), 7'h01);

        // glitch on data bit period 3, tick 8, of 7'h00
        clear_log();
        build(7'h00, 1'b1, 3, 8);
        play(1000, s);
        idle(20);
        chk("glitch_iload", ld_cyc.size(), 1);
        chk("glitch_data", shifted_value(0), 0);

        // reset at frame cycle 60
        clear_log();
        build(7'h55, 1'b1, -1, 0);
        play(62, s);
        RESET = 1'b1;
        #1;
        chk("midrst_busy", int'(Busy), 0);
        chk("midrst_shift_en", int'(ShiftEn), 0);
        chk("midrst_iload", int'(iLoad), 0);
        #1;
        Rx = 1'b1;
        step(); step();
        RESET = 1'b0;
        idle(5);
        clear_log();
        build(7'h2A, 1'b1, -1, 0);
        play(1000, s);
        idle(20);
        chk("after_rst_iload", ld_cyc.size(), 1);
        chk("after_rst_data", shifted_value(0), 7'h2A);

        // Enable dropped at frame cycle 70 for 3 cycles
        clear_log();
        build(7'h7F, 1'b1, -1, 0);
        drop_at = 72;
        play(1000, s);
        idle(20);
        chk("abort_shifts", sh_cyc.size(), 3);
        chk("abort_no_iload", ld_cyc.size(), 0);
        clear_log();
        build(7'h4B, 1'b1, -1, 0);
        play(1000, s);
        idle(20);
        chk("after_abort_iload", ld_cyc.size(), 1);
        chk("after_abort_data", shifted_value(0), 7'h4B);

        // randomized traffic against the model
        for (int r = 0; r < 40; r++) begin
            build(7'($urandom), $urandom_range(0, 5) != 0,
                  ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, DB + 1)) : -1,
                  int'($urandom_range(0, OS - 1)));
            if ($urandom_range(0, 4) == 0) drop_at = int'($urandom_range(0, 150));
            play(1000, s);
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < 12; i++) begin
                    Rx = 1'($urandom);
                    step();
                end
            end
            idle(int'($urandom_range(1, 20)));
        end
        idle(50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
